// File: rtl/intdiv_remul_pkg.sv
// Shared types for the divide-result reconstruction path.
// Holds the controller state encoding used by intdiv_remul.
package intdiv_remul_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_ADD  = 2'b10,
      S_DONE = 2'b11
   } state_e;

   localparam int N_DEF    = 4;
   localparam int CNTW_DEF = 3;

endpackage

// File: rtl/intdiv_booth_step.sv
// One radix-2 Booth step: add/sub sign-extended y into the upper field,
// then arithmetic shift right by one.
module intdiv_booth_step #(
   parameter int N = 4
) (
   input  logic [2*N+1:0] acc_i,
   input  logic [N-1:0]   y_i,
   output logic [2*N+1:0] acc_o
);

   logic [N:0] ys;
   logic [N:0] hi;

   always_comb begin
      ys = {y_i[N-1], y_i};
      hi = acc_i[2*N+1:N+1];
      unique case (acc_i[1:0])
         2'b01:   hi = hi + ys;
         2'b10:   hi = hi - ys;
         default: ;
      endcase
      acc_o = {hi[N], hi, acc_i[N:1]};
   end

endmodule

// File: rtl/intdiv_remul.sv
// Rebuilds the dividend x = z*y + r with a multicycle Booth multiplier
// followed by a remainder-add step; valid/ready on both sides.
import intdiv_remul_pkg::*;

module intdiv_remul #(
   parameter int N    = N_DEF,
   parameter int CNTW = CNTW_DEF
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] z,
   input  logic [N-1:0] y,
   input  logic [N-1:0] r,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] x_out,
   output logic         ovf
);

   localparam int AW = 2*N+2;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N-1);

   state_e          state_q, state_d;
   logic [AW-1:0]   acc_q, acc_d, acc_step;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [N-1:0]    y_q, y_d, r_q, r_d, x_q, x_d;
   logic            ovf_q, ovf_d;
   logic [AW-1:0]   sum_w;
   logic [N+1:0]    top_w;
   logic            unused_lsb;

   intdiv_booth_step #(.N(N)) u_step (
      .acc_i (acc_q),
      .y_i   (y_q),
      .acc_o (acc_step)
   );

   // r is added one bit up so the Booth guard bit stays in place
   assign sum_w      = acc_q + {{(N+1){r_q[N-1]}}, r_q, 1'b0};
   assign top_w      = sum_w[AW-1:N];
   assign unused_lsb = sum_w[0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
         r_q     <= '0;
         x_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         r_q     <= r_d;
         x_q     <= x_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      y_d       = y_q;
      r_d       = r_q;
      x_d       = x_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_d   = {{(N+1){1'b0}}, z, 1'b0};
               y_d     = y;
               r_d     = r;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_ADD;
         end
         S_ADD: begin
            x_d     = sum_w[N:1];
            ovf_d   = ~((&top_w) | ~(|top_w));
            state_d = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: ;
      endcase
   end

   assign x_out = x_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_intdiv_remul.sv
// Directed and exhaustive checks of intdiv_remul at N=4.
// Expected values are hand-computed or taken from integer z*y+r.
module tb_intdiv_remul;

   localparam int PERIOD = 100;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] z = '0, y = '0, r = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] x_out;
   logic       ovf;

   int nvec = 0;
   int nbad = 0;

   intdiv_remul #(.N(4), .CNTW(3)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .z         (z),
      .y         (y),
      .r         (r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .ovf       (ovf)
   );

   always #(PERIOD/2) clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nbad++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Issue one op; returns after the result has been drained (out_ready=1)
   task automatic run_op(input string tag, input logic [3:0] zi,
                         input logic [3:0] yi, input logic [3:0] ri,
                         input logic [3:0] ex, input logic eo,
                         input bit full);
      int lat;
      @(negedge clock);
      if (full) chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      z = zi; y = yi; r = ri;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      z = 4'hx; y = 4'hx; r = 4'hx;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      if (full) begin
         chk({tag, "_lat"}, 32'(lat), 32'd5);
         chk({tag, "_x"}, 32'(x_out), 32'(ex));
         chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
      end else begin
         chk(tag, {27'd0, out_valid, ovf, x_out}, {27'd0, 1'b1, eo, ex});
      end
      @(posedge clock);
      #1;
      if (full) chk({tag, "_drain"}, {30'd0, out_valid, in_ready}, 32'b01);
   endtask

   initial begin
      int p;
      #(PERIOD/4);
      chk("rst_state", {28'd0, in_ready, out_valid, ovf, 1'b0},
          {28'd0, 4'b1000});
      chk("rst_x", 32'(x_out), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      run_op("t1", 4'd2, 4'd3, 4'd1, 4'd7, 1'b0, 1'b1);
      run_op("t2", 4'hE, 4'd3, 4'hF, 4'b1001, 1'b0, 1'b1);
      run_op("t3", 4'h8, 4'h8, 4'd0, 4'd0, 1'b1, 1'b1);
      run_op("t4", 4'd7, 4'd1, 4'd0, 4'd7, 1'b0, 1'b1);
      run_op("t5", 4'd7, 4'd1, 4'd1, 4'h8, 1'b1, 1'b1);
      run_op("t6", 4'd3, 4'd0, 4'hB, 4'hB, 1'b0, 1'b1);

      // back-pressure: hold the result, ignore new requests
      out_ready = 1'b0;
      @(negedge clock);
      in_valid = 1'b1;
      z = 4'd1; y = 4'hF; r = 4'd0;
      @(posedge clock);
      #1;
      z = 4'd2; y = 4'd2; r = 4'd3;
      for (int i = 0; i < 20 && !out_valid; i++) begin
         @(posedge clock);
         #1;
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk("bp_hold", {26'd0, out_valid, in_ready, ovf, 1'b0, x_out},
             {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      chk("bp_drain", {30'd0, out_valid, in_ready}, 32'b01);
      @(negedge clock);
      chk("bp_keep", {27'd0, in_ready, ovf, x_out},
          {27'd0, 1'b1, 1'b0, 4'hF});

      // reset in the middle of BUSY aborts the op
      in_valid = 1'b1;
      z = 4'd5; y = 4'd5; r = 4'd0;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort", {28'd0, out_valid, in_ready, ovf, 1'b0},
          {28'd0, 4'b0100});
      chk("abort_x", 32'(x_out), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         chk("abort_idle", {30'd0, out_valid, in_ready}, 32'b01);
      end
      @(negedge clock);
      reset_n = 1'b1;
      run_op("post_rst", 4'd1, 4'd1, 4'd1, 4'd2, 1'b0, 1'b1);

      for (int zi = -8; zi < 8; zi++)
         for (int yi = -8; yi < 8; yi++)
            for (int ri = -8; ri < 8; ri++) begin
               p = zi * yi + ri;
               run_op("exh", zi[3:0], yi[3:0], ri[3:0], p[3:0],
                      (p > 7) || (p < -8), 1'b0);
            end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
